// File: rtl/insn_pkg.sv
// Shared constants, field bundle and FSM state encoding for the instruction encoder.
package insn_pkg;

    localparam int unsigned WORD_W  = 16;
    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned CNT_W   = 9;
    localparam int unsigned OPC_W   = 3;
    localparam int unsigned OP_W    = 2;
    localparam int unsigned REG_W   = 3;
    localparam int unsigned SHIFT_W = 2;
    localparam int unsigned IMM8_W  = 8;
    localparam int unsigned IMM5_W  = 5;

    // Major opcodes
    localparam logic [OPC_W-1:0] OPC_LDR  = 3'b011;
    localparam logic [OPC_W-1:0] OPC_STR  = 3'b100;
    localparam logic [OPC_W-1:0] OPC_ALU  = 3'b101;
    localparam logic [OPC_W-1:0] OPC_MOV  = 3'b110;
    localparam logic [OPC_W-1:0] OPC_HALT = 3'b111;

    // Sub-opcodes
    localparam logic [OP_W-1:0] OP_NONE    = 2'b00;
    localparam logic [OP_W-1:0] OP_MOV_REG = 2'b00;
    localparam logic [OP_W-1:0] OP_MOV_IMM = 2'b10;
    localparam logic [OP_W-1:0] OP_ADD     = 2'b00;
    localparam logic [OP_W-1:0] OP_CMP     = 2'b01;
    localparam logic [OP_W-1:0] OP_AND     = 2'b10;
    localparam logic [OP_W-1:0] OP_MVN     = 2'b11;

    localparam logic [WORD_W-1:0] HALT_WORD = 16'hE000;
    localparam logic [ADDR_W-1:0] LAST_ADDR = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2,
        ST_FULL = 2'd3
    } state_e;

    // Raw instruction fields as presented on the input side
    typedef struct packed {
        logic [OPC_W-1:0]   opcode;
        logic [OP_W-1:0]    op;
        logic [REG_W-1:0]   rn;
        logic [REG_W-1:0]   rd;
        logic [REG_W-1:0]   rm;
        logic [SHIFT_W-1:0] shift;
        logic [IMM8_W-1:0]  imm8;
        logic [IMM5_W-1:0]  imm5;
    } insn_fields_t;

endpackage

// File: rtl/insn_field_pack.sv
// Combinational field packing and legality check for one instruction.
module insn_field_pack
    import insn_pkg::*;
(
    input  insn_fields_t        fields,
    output logic [WORD_W-1:0]   word,
    output logic                legal
);

    logic [REG_W-1:0] alu_rn;
    logic [REG_W-1:0] alu_rd;

    // CMP has no destination and MVN has no first operand; those fields encode as zero
    always_comb begin
        alu_rn = (fields.op == OP_MVN) ? REG_W'(0) : fields.rn;
        alu_rd = (fields.op == OP_CMP) ? REG_W'(0) : fields.rd;
    end

    // Select the encoding for the opcode/op pair; anything not listed is illegal
    always_comb begin
        word  = '0;
        legal = 1'b0;
        case (fields.opcode)
            OPC_MOV: begin
                if (fields.op == OP_MOV_IMM) begin
                    word  = {OPC_MOV, OP_MOV_IMM, fields.rn, fields.imm8};
                    legal = 1'b1;
                end else if (fields.op == OP_MOV_REG) begin
                    word  = {OPC_MOV, OP_MOV_REG, REG_W'(0), fields.rd, fields.shift, fields.rm};
                    legal = 1'b1;
                end
            end
            OPC_ALU: begin
                word  = {OPC_ALU, fields.op, alu_rn, alu_rd, fields.shift, fields.rm};
                legal = 1'b1;
            end
            OPC_LDR, OPC_STR: begin
                if (fields.op == OP_NONE) begin
                    word  = {fields.opcode, OP_NONE, fields.rn, fields.rd, fields.imm5};
                    legal = 1'b1;
                end
            end
            OPC_HALT: begin
                if (fields.op == OP_NONE) begin
                    word  = HALT_WORD;
                    legal = 1'b1;
                end
            end
            default: begin
                word  = '0;
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/insn_encoder.sv
// Instruction encoder: accepts instruction fields and writes encoded words to instruction memory.
module insn_encoder
    import insn_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                load_addr,
    input  logic [7:0]          start_addr,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [2:0]          opcode,
    input  logic [1:0]          op,
    input  logic [2:0]          rn,
    input  logic [2:0]          rd,
    input  logic [2:0]          rm,
    input  logic [1:0]          shift,
    input  logic [7:0]          imm8,
    input  logic [4:0]          imm5,
    output logic                mem_write,
    output logic [7:0]          mem_addr,
    output logic [15:0]         mem_dout,
    output logic                err,
    output logic [8:0]          count,
    output logic [1:0]          state_o
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                in_ready_q, in_ready_d;
    logic                mem_write_q, mem_write_d;
    logic                err_q, err_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [WORD_W-1:0]   mem_dout_q, mem_dout_d;

    insn_fields_t        fields;
    logic [WORD_W-1:0]   word;
    logic                legal;
    logic                xfer_c;

    // Bundle the input fields for the packer
    always_comb begin
        fields.opcode = opcode;
        fields.op     = op;
        fields.rn     = rn;
        fields.rd     = rd;
        fields.rm     = rm;
        fields.shift  = shift;
        fields.imm8   = imm8;
        fields.imm5   = imm5;
    end

    insn_field_pack u_field_pack (
        .fields (fields),
        .word   (word),
        .legal  (legal)
    );

    // in_ready_q always mirrors (state_q == ST_RUN), so this is the handshake
    always_comb xfer_c = in_valid & in_ready_q;

    // Next-state, pointer, count and output-register logic
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        count_d     = count_q;
        mem_write_d = 1'b0;
        err_d       = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_dout_d  = mem_dout_q;

        if (load_addr) begin
            // Restart wins over any transfer in the same cycle
            state_d = ST_RUN;
            ptr_d   = start_addr;
            count_d = '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (xfer_c) begin
                        if (legal) begin
                            mem_write_d = 1'b1;
                            mem_addr_d  = ptr_q;
                            mem_dout_d  = word;
                            ptr_d       = ptr_q + ADDR_W'(1);
                            count_d     = count_q + CNT_W'(1);
                            if (word == HALT_WORD) begin
                                state_d = ST_DONE;
                            end else if (ptr_q == LAST_ADDR) begin
                                state_d = ST_FULL;
                            end
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end

        in_ready_d = (state_d == ST_RUN);
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            count_q     <= '0;
            in_ready_q  <= 1'b0;
            mem_write_q <= 1'b0;
            err_q       <= 1'b0;
            mem_addr_q  <= '0;
            mem_dout_q  <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            count_q     <= count_d;
            in_ready_q  <= in_ready_d;
            mem_write_q <= mem_write_d;
            err_q       <= err_d;
            mem_addr_q  <= mem_addr_d;
            mem_dout_q  <= mem_dout_d;
        end
    end

    // Drive ports from registers
    always_comb begin
        in_ready  = in_ready_q;
        mem_write = mem_write_q;
        err       = err_q;
        mem_addr  = mem_addr_q;
        mem_dout  = mem_dout_q;
        count     = count_q;
        state_o   = 2'(state_q);
    end

endmodule

// File: doc/insn_encoder.md
INSN_ENCODER -- requirements
Module: insn_encoder

Interface
REQ-001 clk  input  1  single system clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 load_addr  input  1  one-cycle pulse; (re)starts a program at start_addr.
REQ-004 start_addr  input  8  first instruction-memory address of the program.
REQ-005 in_valid  input  1  instruction fields below are valid this cycle.
REQ-006 in_ready  output  1  encoder accepts fields this cycle.
REQ-007 opcode/op/rn/rd/rm/shift/imm8/imm5  input  3/2/3/3/3/2/8/5  Simple RISC instruction fields.
REQ-008 mem_write  output  1  instruction-memory write strobe.
REQ-009 mem_addr  output  8  write address.
REQ-010 mem_dout  output  16  encoded instruction word.
REQ-011 err  output  1  one-cycle pulse: accepted fields form an illegal instruction.
REQ-012 count  output  9  words written since last load_addr.
REQ-013 state_o  output  2  current FSM state, for debug.

Function
REQ-014 The FSM SHALL have states IDLE, RUN, DONE and FULL.
REQ-015 in_ready SHALL be 1 only in RUN and low in IDLE, DONE and FULL.
REQ-016 A transfer SHALL occur on a rising edge where in_valid and in_ready are both 1.
REQ-017 load_addr SHALL, from any state, enter RUN, set the write pointer to start_addr and clear count; any transfer in that same cycle SHALL be dropped.
REQ-018 A legal transfer at edge N SHALL drive mem_write=1 with mem_addr=pointer and mem_dout=encoded word for exactly the cycle following edge N; the pointer SHALL increment by 1 and count by 1 at edge N.
REQ-019 Encodings SHALL be as follows (bit order [15:0]; unused bits 0):
  - MOV imm (110,10): {110,10,rn,imm8}.
  - MOV reg (110,00): {110,00,000,rd,shift,rm}.
  - ALU (101, op 00 ADD/01 CMP/10 AND/11 MVN): {101,op,rn,rd,shift,rm}, with the rd field forced to 000 for CMP and the rn field forced to 000 for MVN.
  - LDR (011,00) and STR (100,00): {opcode,00,rn,rd,imm5}.
  - HALT (111,00): 16'hE000.
REQ-020 Any other opcode/op pair SHALL be illegal: err=1 for the cycle after the transfer, mem_write=0, pointer and count unchanged, and the FSM remains in RUN.
REQ-021 A legal HALT transfer SHALL be written and SHALL move the FSM to DONE.
REQ-022 A legal write at pointer 8'hFF SHALL complete and SHALL move the FSM to FULL; the pointer SHALL NOT wrap into use.
REQ-023 HALT written at 8'hFF SHALL go to DONE (DONE has priority over FULL).
REQ-024 mem_write and err SHALL be registered outputs, never both 1, and 0 whenever no transfer occurred on the preceding edge.
REQ-025 mem_addr and mem_dout SHALL hold their last values while mem_write=0.

Reset
REQ-026 Asserting reset SHALL immediately force state IDLE, in_ready=0, mem_write=0, err=0, mem_addr=0, mem_dout=0, count=0 and pointer=0.
REQ-027 Reset asserted mid-write SHALL abort that strobe without waiting for a clock edge.
REQ-028 After reset deassertion the block SHALL remain in IDLE until load_addr.

Structure
REQ-029 A shared package insn_pkg SHALL hold the opcode/op constants, the state encoding and the HALT word constant.
REQ-030 The combinational field-packing and legality check SHALL be one sub-module, insn_field_pack (fields in; word and legal out); insn_encoder holds the FSM, pointer, count and output registers.

Verification
REQ-031 Reset, then load_addr with start_addr=8'h10; send MOV imm rn=1 imm8=8'h07 -> mem_write at 8'h10 with mem_dout=16'hD107, count=1.
REQ-032 Back-to-back transfers: ADD rn=2 rd=3 shift=01 rm=1, then LDR rn=2 rd=1 imm5=5 -> 16'hA269 @8'h11 and 16'h6225 @8'h12 on consecutive cycles.
REQ-033 opcode=000 op=00 -> err pulse, no write, pointer unchanged; the next legal instruction lands at the unchanged pointer.
REQ-034 HALT -> 16'hE000 written and state DONE, in_ready=0; further in_valid is ignored; load_addr returns to RUN with count=0.
REQ-035 load_addr start_addr=8'hFE, then three MOV reg -> writes at FE and FF, then FULL; the third is not accepted.
REQ-036 Assert reset between the transfer edge and the strobe cycle -> mem_write drops immediately, all outputs equal their reset values, and the state is IDLE.
